// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_types
// Purpose  : Shared types for the rv32i core; holds the hazard controller
//            sequencing state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_types;

  // Sequencing state of the hazard controller.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } hazard_state_t;

endpackage : rv32i_types
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that sticks at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_max = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q;

  // Count requested events, holding at the maximum value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (inc && (count_q != c_max)) begin
      count_q <= count_q + c_one;
    end
  end

  assign count = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Five-stage pipeline sequencing: register enables, PC redirect and
//            per-stage bubble flags from load-use, mispredict and cache misses.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bubble_req,
  input  logic             br_mispredict,
  input  logic [31:0]      br_target,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_access,
  input  logic             dmem_resp,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             pc_redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             flush_mem_wb,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hazard_state_t state_q, state_d;
  logic [31:0]   redirect_pc_q, redirect_pc_d;
  logic          flush_if_id_q, flush_if_id_d;
  logic          flush_id_ex_q, flush_id_ex_d;
  logic          flush_ex_mem_q, flush_ex_mem_d;
  logic          flush_mem_wb_q, flush_mem_wb_d;
  logic          stall_inc, bubble_inc, flush_inc;

  logic imiss, dmiss, miss, mp_valid;

  assign imiss    = imem_read & ~imem_resp;
  assign dmiss    = dmem_access & ~dmem_resp;
  assign miss     = imiss | dmiss;
  // A bubble in EX cannot carry a real branch.
  assign mp_valid = br_mispredict & ~flush_id_ex_q;

  // Per-cycle decision: miss > pending redirect > mispredict > load-use.
  always_comb begin
    state_d        = RUN;
    redirect_pc_d  = redirect_pc_q;
    load_pc        = 1'b1;
    load_if_id     = 1'b1;
    load_id_ex     = 1'b1;
    load_ex_mem    = 1'b1;
    load_mem_wb    = 1'b1;
    pc_redirect    = 1'b0;
    flush_if_id_d  = 1'b0;
    flush_id_ex_d  = flush_if_id_q;
    flush_ex_mem_d = flush_id_ex_q;
    flush_mem_wb_d = flush_ex_mem_q;
    stall_inc      = 1'b0;
    bubble_inc     = 1'b0;
    flush_inc      = 1'b0;

    if (miss) begin
      // Freeze everything upstream; WB retires once and then holds a bubble.
      load_pc        = 1'b0;
      load_if_id     = 1'b0;
      load_id_ex     = 1'b0;
      load_ex_mem    = 1'b0;
      flush_if_id_d  = flush_if_id_q;
      flush_id_ex_d  = flush_id_ex_q;
      flush_ex_mem_d = flush_ex_mem_q;
      flush_mem_wb_d = 1'b1;
      stall_inc      = 1'b1;
      if (state_q == REDIRECT) begin
        // Target already captured; keep it until the fetch drains.
        state_d = REDIRECT;
      end else if (mp_valid && imiss) begin
        // Wrong-path fetch in flight: remember the target, redirect later.
        state_d       = REDIRECT;
        redirect_pc_d = br_target;
      end else begin
        state_d = STALL;
      end
    end else if (state_q == REDIRECT) begin
      // Deferred mispredict: steer PC and squash the two younger stages.
      pc_redirect   = 1'b1;
      flush_if_id_d = 1'b1;
      flush_id_ex_d = 1'b1;
      flush_inc     = 1'b1;
    end else if (mp_valid) begin
      // PC takes br_target directly; the branch itself moves on to MEM.
      pc_redirect   = 1'b1;
      flush_if_id_d = 1'b1;
      flush_id_ex_d = 1'b1;
      flush_inc     = 1'b1;
    end else if (bubble_req) begin
      // Hold the consumer in ID/EX for one cycle, insert a bubble in MEM.
      load_pc        = 1'b0;
      load_if_id     = 1'b0;
      load_id_ex     = 1'b0;
      flush_if_id_d  = flush_if_id_q;
      flush_id_ex_d  = flush_id_ex_q;
      flush_ex_mem_d = 1'b1;
      bubble_inc     = 1'b1;
    end
  end

  // State, redirect target and bubble flags; reset bubbles every stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      redirect_pc_q  <= 32'h0;
      flush_if_id_q  <= 1'b1;
      flush_id_ex_q  <= 1'b1;
      flush_ex_mem_q <= 1'b1;
      flush_mem_wb_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      redirect_pc_q  <= redirect_pc_d;
      flush_if_id_q  <= flush_if_id_d;
      flush_id_ex_q  <= flush_id_ex_d;
      flush_ex_mem_q <= flush_ex_mem_d;
      flush_mem_wb_q <= flush_mem_wb_d;
    end
  end

  assign redirect_pc  = redirect_pc_q;
  assign flush_if_id  = flush_if_id_q;
  assign flush_id_ex  = flush_id_ex_q;
  assign flush_ex_mem = flush_ex_mem_q;
  assign flush_mem_wb = flush_mem_wb_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed self-checking bench for hazard_ctrl (CNT_W = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             bubble_req;
  logic             br_mispredict;
  logic [31:0]      br_target;
  logic             imem_read;
  logic             imem_resp;
  logic             dmem_access;
  logic             dmem_resp;
  logic             load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic             pc_redirect;
  logic [31:0]      redirect_pc;
  logic             flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;

  logic [3:0] flags;
  logic [4:0] loads;
  assign flags = {flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb};
  assign loads = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .bubble_req    (bubble_req),
    .br_mispredict (br_mispredict),
    .br_target     (br_target),
    .imem_read     (imem_read),
    .imem_resp     (imem_resp),
    .dmem_access   (dmem_access),
    .dmem_resp     (dmem_resp),
    .load_pc       (load_pc),
    .load_if_id    (load_if_id),
    .load_id_ex    (load_id_ex),
    .load_ex_mem   (load_ex_mem),
    .load_mem_wb   (load_mem_wb),
    .pc_redirect   (pc_redirect),
    .redirect_pc   (redirect_pc),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .flush_ex_mem  (flush_ex_mem),
    .flush_mem_wb  (flush_mem_wb),
    .stall_cnt     (stall_cnt),
    .bubble_cnt    (bubble_cnt),
    .flush_cnt     (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change in the low phase; outputs are sampled 1 ns later.
  task automatic set_in(input logic br, input logic [31:0] tgt, input logic bub,
                        input logic ir, input logic irs, input logic da, input logic drs);
    br_mispredict = br;
    br_target     = tgt;
    bubble_req    = bub;
    imem_read     = ir;
    imem_resp     = irs;
    dmem_access   = da;
    dmem_resp     = drs;
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    set_in(0, 32'h0, 0, 0, 0, 0, 0);
    step(2);

    // Reset state
    check_eq("rst_flags", {28'h0, flags}, 32'hF);
    check_eq("rst_stall", {28'h0, stall_cnt}, 32'h0);
    check_eq("rst_bubble", {28'h0, bubble_cnt}, 32'h0);
    check_eq("rst_flush", {28'h0, flush_cnt}, 32'h0);
    check_eq("rst_rpc", redirect_pc, 32'h0);
    check_eq("rst_loads", {27'h0, loads}, 32'h1F);

    // Bubbles drain one stage per cycle
    rst = 1'b1;
    step(1);
    check_eq("adv1_flags", {28'h0, flags}, 32'h7);
    step(3);
    check_eq("adv4_flags", {28'h0, flags}, 32'h0);

    // Load-use: one-cycle hold of PC, IF/ID, ID/EX
    set_in(0, 32'h0, 1, 0, 0, 0, 0);
    check_eq("lu_loads", {27'h0, loads}, 32'h03);
    check_eq("lu_redir", {31'h0, pc_redirect}, 32'h0);
    step(1);
    set_in(0, 32'h0, 0, 0, 0, 0, 0);
    check_eq("lu_flags", {28'h0, flags}, 32'h2);
    check_eq("lu_bcnt", {28'h0, bubble_cnt}, 32'h1);
    step(1);
    check_eq("lu_flags2", {28'h0, flags}, 32'h1);

    // Mispredict without miss
    set_in(1, 32'h60, 0, 0, 0, 0, 0);
    check_eq("mp_loads", {27'h0, loads}, 32'h1F);
    check_eq("mp_redir", {31'h0, pc_redirect}, 32'h1);
    step(1);
    set_in(0, 32'h0, 0, 0, 0, 0, 0);
    check_eq("mp_flags", {28'h0, flags}, 32'hC);
    check_eq("mp_fcnt", {28'h0, flush_cnt}, 32'h1);

    // Mispredict ignored while EX holds a bubble
    set_in(1, 32'h70, 0, 0, 0, 0, 0);
    check_eq("ign_redir", {31'h0, pc_redirect}, 32'h0);
    step(1);
    set_in(0, 32'h0, 0, 0, 0, 0, 0);
    check_eq("ign_flags", {28'h0, flags}, 32'h6);
    check_eq("ign_fcnt", {28'h0, flush_cnt}, 32'h1);
    step(3);
    check_eq("ign_clear", {28'h0, flags}, 32'h0);

    // Simultaneous load-use and mispredict: mispredict wins
    set_in(1, 32'h40, 1, 0, 0, 0, 0);
    check_eq("sim_loads", {27'h0, loads}, 32'h1F);
    check_eq("sim_redir", {31'h0, pc_redirect}, 32'h1);
    step(1);
    set_in(0, 32'h0, 0, 0, 0, 0, 0);
    check_eq("sim_flags", {28'h0, flags}, 32'hC);
    check_eq("sim_bcnt", {28'h0, bubble_cnt}, 32'h1);
    check_eq("sim_fcnt", {28'h0, flush_cnt}, 32'h2);
    step(4);

    // Mispredict during a 3-cycle instruction miss
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'h80, 0, 1, 0, 0, 0);
      check_eq("rd_hold_loads", {27'h0, loads}, 32'h01);
      check_eq("rd_hold_redir", {31'h0, pc_redirect}, 32'h0);
      step(1);
    end
    check_eq("rd_rpc", redirect_pc, 32'h80);
    check_eq("rd_flags_hold", {28'h0, flags}, 32'h1);
    set_in(1, 32'h80, 0, 1, 1, 0, 0);
    check_eq("rd_go_loads", {27'h0, loads}, 32'h1F);
    check_eq("rd_go_redir", {31'h0, pc_redirect}, 32'h1);
    step(1);
    set_in(0, 32'h0, 0, 0, 0, 0, 0);
    check_eq("rd_flags", {28'h0, flags}, 32'hC);
    check_eq("rd_stall", {28'h0, stall_cnt}, 32'h3);
    check_eq("rd_run_loads", {27'h0, loads}, 32'h1F);
    check_eq("rd_run_redir", {31'h0, pc_redirect}, 32'h0);
    step(4);

    // Fresh reset before the data-miss sequence
    rst = 1'b0;
    #1;
    check_eq("rst2_flags", {28'h0, flags}, 32'hF);
    check_eq("rst2_stall", {28'h0, stall_cnt}, 32'h0);
    rst = 1'b1;
    step(4);

    // Data miss for 5 cycles
    set_in(0, 32'h0, 0, 0, 0, 1, 0);
    check_eq("dm_loads", {27'h0, loads}, 32'h01);
    step(1);
    for (int i = 0; i < 4; i++) begin
      check_eq("dm_wb_bubble", {31'h0, flush_mem_wb}, 32'h1);
      check_eq("dm_hold_loads", {27'h0, loads}, 32'h01);
      step(1);
    end
    set_in(0, 32'h0, 0, 0, 0, 1, 1);
    check_eq("dm_resume_loads", {27'h0, loads}, 32'h1F);
    check_eq("dm_stall", {28'h0, stall_cnt}, 32'h5);
    check_eq("dm_flags", {28'h0, flags}, 32'h1);
    step(1);
    set_in(0, 32'h0, 0, 0, 0, 0, 0);
    check_eq("dm_no_dup_wb", {28'h0, flags}, 32'h0);
    check_eq("dm_stall2", {28'h0, stall_cnt}, 32'h5);

    // Counter saturation over 20 more stall cycles
    set_in(0, 32'h0, 0, 0, 0, 1, 0);
    step(10);
    check_eq("sat_15a", {28'h0, stall_cnt}, 32'hF);
    step(10);
    check_eq("sat_15b", {28'h0, stall_cnt}, 32'hF);
    check_eq("sat_loads", {27'h0, loads}, 32'h01);

    // Reset in the middle of a stall
    rst = 1'b0;
    #1;
    check_eq("mrst_flags", {28'h0, flags}, 32'hF);
    check_eq("mrst_stall", {28'h0, stall_cnt}, 32'h0);
    check_eq("mrst_flush", {28'h0, flush_cnt}, 32'h0);
    rst = 1'b1;
    set_in(0, 32'h0, 0, 0, 0, 0, 0);
    check_eq("mrst_loads", {27'h0, loads}, 32'h1F);
    step(1);
    check_eq("mrst_adv", {28'h0, flags}, 32'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_hazard_ctrl
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage rv32i core. Each cycle it decides the load enable of the PC and of each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB), and sets the per-stage bubble flags. Its inputs are the forwarding logic's load-use bubble request, the branch-mispredict signal from EX, and the instruction/data cache handshakes. The registered bubble flags `flush_ex_mem` / `flush_mem_wb` are the same signals the forwarding logic consumes to ignore invalid stages.

## Interface
- `CNT_W`, default 32: width of each saturating performance counter.
- `clk`  in  1: core clock.
- `rst`  in  1: asynchronous, active-low reset.
- `bubble_req`  in  1: load-use hazard between EX and MEM (combinational from forwarding logic).
- `br_mispredict`  in  1: branch/jump in EX resolved to a PC other than the fetched path.
- `br_target`  in  32: correct PC, valid with `br_mispredict`.
- `imem_read`  in  1: IF fetch outstanding.
- `imem_resp`  in  1: IF fetch complete this cycle.
- `dmem_access`  in  1: MEM stage holds a load/store (already gated by `~flush_ex_mem`).
- `dmem_resp`  in  1: data access complete this cycle.
- `load_pc`, `load_if_id`, `load_id_ex`, `load_ex_mem`, `load_mem_wb`  out  1 each: register enables.
- `pc_redirect`  out  1: PC mux selects `redirect_pc` when `load_pc`.
- `redirect_pc`  out  32: registered target.
- `flush_if_id`, `flush_id_ex`, `flush_ex_mem`, `flush_mem_wb`  out  1 each: registered "stage holds a bubble".
- `stall_cnt`, `bubble_cnt`, `flush_cnt`  out  `CNT_W` each: performance counters.

## Operation
- Definitions:
  - `imiss = imem_read & ~imem_resp`
  - `dmiss = dmem_access & ~dmem_resp`
  - `miss = imiss | dmiss`
- States: `RUN`, `STALL`, `REDIRECT`. State, all flush flags and all counters reset asynchronously.
- Reset values:
  - every `flush_*` = 1
  - `redirect_pc` = 0
  - counters = 0
  - state = `RUN`
- Priority, evaluated per cycle: miss > mispredict > load-use.
- Miss, any state:
  - all loads 0 except `load_mem_wb` = 1.
  - `flush_mem_wb` ← 1, so the WB instruction retires exactly once.
  - state → `STALL`; `stall_cnt`++.
- `STALL`, no miss: all loads 1, state → `RUN`. `flush_mem_wb` ← `flush_ex_mem`; every flag shifts normally.
- Mispredict with `imiss` set: `redirect_pc` ← `br_target`, state → `REDIRECT`. The wrong-path fetch cannot be aborted.
- Mispredict with no miss:
  - all loads 1, `pc_redirect` = 1, PC ← `br_target` directly.
  - `flush_if_id` ← 1, `flush_id_ex` ← 1.
  - `flush_ex_mem` ← `flush_id_ex` (the branch itself survives).
  - `flush_cnt`++.
- `REDIRECT`:
  - Hold all stages while `imiss`.
  - On the first non-miss cycle: `load_pc` = 1, `pc_redirect` = 1, flush IF/ID and ID/EX as above, state → `RUN`.
  - A `dmiss` in `REDIRECT` keeps the state; `redirect_pc` is not overwritten.
- Load-use (`bubble_req`, no miss, no mispredict):
  - `load_pc` = `load_if_id` = `load_id_ex` = 0; `load_ex_mem` = `load_mem_wb` = 1.
  - `flush_ex_mem` ← 1; `bubble_cnt`++.
- Normal advance: each `flush_*` takes the previous stage's flag; `flush_if_id` ← 0.
- Counters saturate at all-ones and never wrap.
- `br_mispredict` is ignored when `flush_id_ex` = 1, because EX holds a bubble.

## Timing
- All outputs except `load_*` and `pc_redirect` are registered; `load_*` and `pc_redirect` are combinational from the current state and inputs.
- Load-use costs exactly 1 cycle. In the next cycle the load is in WB, `flush_ex_mem` = 1, and `bubble_req` deasserts.
- Mispredict penalty is 2 cycles with no miss; plus the remaining `imiss` cycles in `REDIRECT`.
- Simultaneous `bubble_req` and `br_mispredict`: mispredict wins and the dependent instruction is flushed.
- Reset mid-stall returns to `RUN` with all stages bubbled.

## Structure
- Add `hazard_state_t` (`RUN`, `STALL`, `REDIRECT`) to `rv32i_types`.
- One sub-module, `sat_counter #(CNT_W)`, with inputs `clk`, `rst`, `inc` and output `count`, instantiated three times.

## Test plan
- Reset, then release: all `flush_*` = 1, counters 0. After 4 unstalled cycles every `flush_*` = 0.
- `lw x1` then `add x2,x1,x3` with `bubble_req` for 1 cycle: `load_pc`/`load_if_id`/`load_id_ex` = 0 that cycle. Next cycle `flush_ex_mem` = 1 and `bubble_cnt` = 1.
- `br_mispredict` with `br_target` = 0x60: PC loads 0x60. Next cycle `flush_if_id` = `flush_id_ex` = 1, `flush_ex_mem` = 0, `flush_cnt` = 1.
- Mispredict to 0x80 while `imiss` holds 3 cycles: state `REDIRECT`, no loads for 3 cycles, then `pc_redirect` = 1 with PC = 0x80.
- `dmiss` for 5 cycles: upstream loads 0, `flush_mem_wb` = 1 from cycle 2, `stall_cnt` = 5. Pipeline resumes without duplicate writeback.
- Force `stall_cnt` near all-ones (`CNT_W` = 4, 20 stall cycles): counter holds at 15.
